// File: rtl/intercal_pkg.sv
// Shared definitions for the INTERCAL-style sequential ALU: operation codes,
// controller states and the operand-width legality check.
package intercal_pkg;

   // Operation codes as presented on the op port. Codes 5..7 are illegal
   // and still go through a one-cycle busy phase before flagging err.
   typedef enum logic [2:0] {
      OP_MINGLE = 3'd0,
      OP_SELECT = 3'd1,
      OP_AND    = 3'd2,
      OP_OR     = 3'd3,
      OP_XOR    = 3'd4
   } op_e;

   // Controller states; the encoding is also what the debug state port shows.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Highest op code that names a real operation.
   localparam logic [2:0] OP_LAST_LEGAL = 3'd4;

   // Operand widths the datapath is built for (whole bytes, power of two).
   function automatic bit width_is_legal(input int w);
      return (w == 16) || (w == 32) || (w == 64);
   endfunction

   // True when an op code selects one of the five real operations.
   function automatic logic op_is_legal(input logic [2:0] op);
      return op <= OP_LAST_LEGAL;
   endfunction

endpackage

// File: rtl/intercal_select_serial.sv
// Bit-serial SELECT engine. Walks one operand bit per cycle and packs the
// A bits whose B bit is set towards the LSB of the result.
module intercal_select_serial
   import intercal_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,   // start of a new operation
   input  logic             step_i,    // process one bit this cycle
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,    // this step handles bit WIDTH-1
   output logic [WIDTH-1:0] result_o   // packed value including this step
);

   localparam int CW = $clog2(WIDTH);

   // cnt is the bit being scanned, k the next free result bit. k needs one
   // extra bit so that a fully-set B can count all the way to WIDTH.
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW:0]      k_q, k_d;
   logic [WIDTH-1:0] pack_q, pack_d;

   // Next-state for one scan step; clear wins so a fresh op never inherits
   // bits from the previous one.
   always_comb begin
      cnt_d  = cnt_q;
      k_d    = k_q;
      pack_d = pack_q;
      if (clear_i) begin
         cnt_d  = '0;
         k_d    = '0;
         pack_d = '0;
      end else if (step_i) begin
         if (b_i[cnt_q]) begin
            pack_d[k_q[CW-1:0]] = a_i[cnt_q];
            k_d                 = k_q + (CW+1)'(1);
         end
         cnt_d = cnt_q + CW'(1);
      end
   end

   // The final step's bit must land in the same edge that the controller
   // captures the result, so the packed value is exported pre-register.
   assign last_o   = step_i && (cnt_q == CW'(WIDTH - 1));
   assign result_o = pack_d;

   // Scan state registers; reset clears any partially packed result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         k_q    <= '0;
         pack_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         k_q    <= k_d;
         pack_q <= pack_d;
      end
   end

endmodule

// File: rtl/intercal_seq_alu.sv
// INTERCAL-flavoured sequential ALU: byte-loaded operands A/B, a controller
// that runs MINGLE / SELECT / unary AND-OR-XOR, and a byte-addressed result.
//
// Handshake: start is a one-cycle request. It is accepted on a rising edge
// only while busy is low (IDLE or DONE); the accept edge raises busy and
// drops done. busy stays high for the whole operation, and done rises on the
// edge that lowers busy, holding until the next accepted start or any ld_en.
// busy and done are never high together. Requests made while busy are lost.
module intercal_seq_alu
   import intercal_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int BYTES = WIDTH / 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ld_en,
   input  logic [$clog2(2*BYTES)-1:0]   ld_sel,
   input  logic [7:0]                   ld_data,
   input  logic [2:0]                   op,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   input  logic [$clog2(BYTES)-1:0]     rd_sel,
   output logic [7:0]                   rd_data,
   output logic [1:0]                   dbg_state_o
);

   localparam int LSW = $clog2(2 * BYTES);
   localparam int RSW = $clog2(BYTES);

   if (!width_is_legal(WIDTH)) begin : g_bad_width
      $error("intercal_seq_alu: WIDTH must be 16, 32 or 64");
   end

   // Controller state and registered status outputs.
   state_e           state_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;

   // User-visible operands and the snapshot the running op works on.
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] wa_q, wb_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] res_q;

   logic             accept;
   logic             load_ok;
   logic             ld_is_b;
   logic [RSW+2:0]   ld_bit;
   logic [WIDTH-1:0] rot;
   logic [WIDTH-1:0] quick_res;
   logic             sel_step;
   logic             sel_last;
   logic [WIDTH-1:0] sel_result;

   // A request only counts outside BUSY; loads are dropped during BUSY too.
   assign accept  = start && (state_q != ST_BUSY);
   assign load_ok = ld_en && (state_q != ST_BUSY);
   assign ld_is_b = ld_sel[LSW-1];
   assign ld_bit  = {ld_sel[RSW-1:0], 3'b000};

   // Operand byte loads. A load in the accept cycle commits here while the
   // snapshot below still takes the pre-edge operand value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else if (load_ok) begin
         if (ld_is_b) begin
            b_q[ld_bit +: 8] <= ld_data;
         end else begin
            a_q[ld_bit +: 8] <= ld_data;
         end
      end
   end

   // Single-cycle operations evaluated from the snapshot registers.
   always_comb begin
      quick_res = '0;
      rot       = {wa_q[0], wa_q[WIDTH-1:1]};
      case (op_q)
         OP_MINGLE: begin
            for (int i = 0; i < WIDTH / 2; i++) begin
               quick_res[2*i+1] = wa_q[i];
               quick_res[2*i]   = wb_q[i];
            end
         end
         OP_AND:  quick_res = wa_q & rot;
         OP_OR:   quick_res = wa_q | rot;
         OP_XOR:  quick_res = wa_q ^ rot;
         default: quick_res = '0;
      endcase
   end

   assign sel_step = (state_q == ST_BUSY) && (op_q == OP_SELECT);

   intercal_select_serial #(
      .WIDTH (WIDTH)
   ) u_select (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (accept),
      .step_i   (sel_step),
      .a_i      (wa_q),
      .b_i      (wb_q),
      .last_o   (sel_last),
      .result_o (sel_result)
   );

   // Controller: accepts requests, sequences BUSY and writes the result
   // register only on the BUSY->DONE edge so rd_data is stable while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         op_q    <= '0;
         wa_q    <= '0;
         wb_q    <= '0;
         res_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  state_q <= ST_BUSY;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  op_q    <= op;
                  wa_q    <= a_q;
                  wb_q    <= b_q;
                  if (op_is_legal(op)) begin
                     err_q <= 1'b0;
                  end
               end else if (ld_en) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (op_q == OP_SELECT) begin
                  if (sel_last) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     res_q   <= sel_result;
                  end
               end else begin
                  // Illegal codes fall through quick_res as zero.
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= !op_is_legal(op_q);
                  res_q   <= quick_res;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Result byte view. Lanes past the last byte read as zero; with the legal
   // widths every rd_sel code maps to a real byte.
   logic [7:0] res_bytes [0:(1<<RSW)-1];

   for (genvar g = 0; g < (1 << RSW); g++) begin : g_rd
      if (g < BYTES) begin : g_lane
         assign res_bytes[g] = res_q[8*g +: 8];
      end else begin : g_pad
         assign res_bytes[g] = 8'h00;
      end
   end

   assign rd_data     = res_bytes[rd_sel];
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_intercal_seq_alu.sv
// Bench for intercal_seq_alu at WIDTH 16, 32 and 64. Expected results come
// from an independent reference model and flow through a scoreboard queue.
module tb_intercal_seq_alu;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   // Per-instance stimulus and observation (index 0:W16, 1:W32, 2:W64).
   logic [2:0]       ld_en_v;
   logic [2:0]       start_v;
   logic [2:0][3:0]  ld_sel_v;
   logic [2:0][7:0]  ld_data_v;
   logic [2:0][2:0]  op_v;
   logic [2:0][2:0]  rd_sel_v;
   logic [2:0]       busy_v;
   logic [2:0]       done_v;
   logic [2:0]       err_v;
   logic [2:0][7:0]  rd_data_v;
   logic [2:0][1:0]  dbg_v;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W   = 16 << g;
      localparam int BY  = W / 8;
      localparam int LSW = $clog2(2 * BY);
      localparam int RSW = $clog2(BY);
      intercal_seq_alu #(.WIDTH(W)) u_dut (
         .clk         (clk),
         .rst         (rst),
         .ld_en       (ld_en_v[g]),
         .ld_sel      (ld_sel_v[g][LSW-1:0]),
         .ld_data     (ld_data_v[g]),
         .op          (op_v[g]),
         .start       (start_v[g]),
         .busy        (busy_v[g]),
         .done        (done_v[g]),
         .err         (err_v[g]),
         .rd_sel      (rd_sel_v[g][RSW-1:0]),
         .rd_data     (rd_data_v[g]),
         .dbg_state_o (dbg_v[g])
      );
   end

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] a_m [3];
   logic [63:0] b_m [3];
   logic [63:0] last_res [3];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int width_of(input int d);
      return 16 << d;
   endfunction

   function automatic logic [63:0] mask_w(input int w);
      if (w == 64) return '1;
      return (64'd1 << w) - 64'd1;
   endfunction

   // Reference model written straight from the operation definitions.
   function automatic logic [63:0] model(input logic [2:0] opc, input logic [63:0] a_in,
                                         input logic [63:0] b_in, input int w);
      logic [63:0] a, b, r, rot;
      int k;
      a   = a_in & mask_w(w);
      b   = b_in & mask_w(w);
      r   = '0;
      k   = 0;
      rot = (a >> 1) | ({63'd0, a[0]} << (w - 1));
      case (opc)
         3'd0: for (int i = 0; i < w / 2; i++) begin
            r[2*i+1] = a[i];
            r[2*i]   = b[i];
         end
         3'd1: for (int i = 0; i < w; i++) begin
            if (b[i]) begin
               r[k] = a[i];
               k++;
            end
         end
         3'd2:    r = a & rot;
         3'd3:    r = a | rot;
         3'd4:    r = a ^ rot;
         default: r = '0;
      endcase
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic read_result(input int d, output logic [63:0] r);
      r = '0;
      for (int i = 0; i < width_of(d) / 8; i++) begin
         rd_sel_v[d] = 3'(i);
         #1;
         r[8*i +: 8] = rd_data_v[d];
      end
   endtask

   task automatic load_operands(input int d, input logic [63:0] a, input logic [63:0] b);
      int nb;
      nb = width_of(d) / 8;
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         ld_en_v[d]   = 1'b1;
         ld_sel_v[d]  = 4'(i);
         ld_data_v[d] = a[8*i +: 8];
      end
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         ld_en_v[d]   = 1'b1;
         ld_sel_v[d]  = 4'((1 << (d + 1)) | i);
         ld_data_v[d] = b[8*i +: 8];
      end
      @(negedge clk);
      ld_en_v[d] = 1'b0;
      a_m[d] = a & mask_w(width_of(d));
      b_m[d] = b & mask_w(width_of(d));
      check("done_after_load", 64'(done_v[d]), 64'd0);
      check("state_after_load", 64'(dbg_v[d]), 64'd0);
   endtask

   // Runs one op. inject_at > 0 pulses start + ld_en (A byte0 = 0xEE) on that
   // busy cycle; acc_load writes A byte0 in the same cycle as start.
   task automatic run_op(input int d, input logic [2:0] opc, input int inject_at,
                         input bit acc_load, input logic [7:0] acc_data);
      int          w, cnt, exp_busy;
      logic        exp_err;
      logic [63:0] got, exp;
      w        = width_of(d);
      exp_err  = (opc > 3'd4);
      exp_busy = (opc == 3'd1) ? w : 1;
      exp_q.push_back(model(opc, a_m[d], b_m[d], w));
      @(negedge clk);
      start_v[d] = 1'b1;
      op_v[d]    = opc;
      if (acc_load) begin
         ld_en_v[d]   = 1'b1;
         ld_sel_v[d]  = 4'd0;
         ld_data_v[d] = acc_data;
      end
      @(negedge clk);
      start_v[d] = 1'b0;
      ld_en_v[d] = 1'b0;
      if (acc_load) a_m[d][7:0] = acc_data;
      cnt = 0;
      while (busy_v[d] === 1'b1 && cnt < 200) begin
         cnt++;
         if (cnt == 1) begin
            rd_sel_v[d] = 3'd0;
            #1;
            check("rd_during_busy", 64'(rd_data_v[d]), 64'(last_res[d][7:0]));
            check("done_low_in_busy", 64'(done_v[d]), 64'd0);
         end
         if (cnt == inject_at) begin
            start_v[d]   = 1'b1;
            op_v[d]      = 3'd2;
            ld_en_v[d]   = 1'b1;
            ld_sel_v[d]  = 4'd0;
            ld_data_v[d] = 8'hEE;
         end
         @(negedge clk);
         start_v[d] = 1'b0;
         ld_en_v[d] = 1'b0;
      end
      check("busy_cycles", 64'(cnt), 64'(exp_busy));
      check("done", 64'(done_v[d]), 64'd1);
      check("err", 64'(err_v[d]), 64'(exp_err));
      check("state_done", 64'(dbg_v[d]), 64'd2);
      read_result(d, got);
      exp = exp_q.pop_front();
      check("result", got, exp);
      last_res[d] = exp;
   endtask

   task automatic check_idle_after_reset(input int d);
      logic [63:0] got;
      check("rst_busy", 64'(busy_v[d]), 64'd0);
      check("rst_done", 64'(done_v[d]), 64'd0);
      check("rst_err", 64'(err_v[d]), 64'd0);
      check("rst_state", 64'(dbg_v[d]), 64'd0);
      read_result(d, got);
      check("rst_result", got, 64'd0);
   endtask

   task automatic clear_models();
      for (int d = 0; d < 3; d++) begin
         a_m[d]      = '0;
         b_m[d]      = '0;
         last_res[d] = '0;
      end
   endtask

   // Reset in the middle of a SELECT, then load on the very first edge after.
   task automatic reset_mid_busy(input int d);
      @(negedge clk);
      start_v[d] = 1'b1;
      op_v[d]    = 3'd1;
      @(negedge clk);
      start_v[d] = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_before_rst", 64'(busy_v[d]), 64'd1);
      rst = 1'b1;
      #1;
      clear_models();
      check_idle_after_reset(d);
      @(negedge clk);
      rst          = 1'b0;
      ld_en_v[d]   = 1'b1;
      ld_sel_v[d]  = 4'd0;
      ld_data_v[d] = 8'h5A;
      @(negedge clk);
      ld_en_v[d] = 1'b0;
      a_m[d][7:0] = 8'h5A;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [63:0] ra, rb;
      logic [2:0]  ro;
      rst       = 1'b1;
      ld_en_v   = '0;
      start_v   = '0;
      ld_sel_v  = '0;
      ld_data_v = '0;
      op_v      = '0;
      rd_sel_v  = '0;
      clear_models();
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) check_idle_after_reset(d);
      rst = 1'b0;

      // Directed WIDTH=32 cases.
      load_operands(1, 64'h12345678, 64'h0000FFFF);
      run_op(1, 3'd1, 0, 1'b0, 8'h00);
      load_operands(1, 64'hFFFFFFFF, 64'h80000001);
      run_op(1, 3'd1, 0, 1'b0, 8'h00);
      load_operands(1, 64'h0000FFFF, 64'h0);
      run_op(1, 3'd0, 0, 1'b0, 8'h00);
      load_operands(1, 64'h00000003, 64'h0);
      run_op(1, 3'd2, 0, 1'b0, 8'h00);
      load_operands(1, 64'h00000001, 64'h0);
      run_op(1, 3'd4, 0, 1'b0, 8'h00);
      load_operands(1, 64'hF0F0000F, 64'h0);
      run_op(1, 3'd3, 0, 1'b0, 8'h00);
      run_op(1, 3'd6, 0, 1'b0, 8'h00);
      run_op(1, 3'd2, 0, 1'b0, 8'h00);

      // start/ld_en during busy cycle 10 must be ignored, A kept.
      load_operands(1, 64'h12345678, 64'h0000FFFF);
      run_op(1, 3'd1, 10, 1'b0, 8'h00);
      run_op(1, 3'd2, 0, 1'b0, 8'h00);

      // From DONE: start and load in the same cycle; op sees old A.
      run_op(1, 3'd1, 0, 1'b1, 8'h00);
      run_op(1, 3'd2, 0, 1'b0, 8'h00);

      // Random WIDTH=32 traffic, all op codes.
      repeat (6) begin
         ra = {32'd0, $urandom};
         rb = {32'd0, $urandom};
         ro = 3'($urandom_range(0, 7));
         load_operands(1, ra, rb);
         run_op(1, ro, 0, 1'b0, 8'h00);
      end

      // Scaled SELECT on the 16- and 64-bit instances plus a random op each.
      load_operands(0, 64'h5678, 64'h00FF);
      run_op(0, 3'd1, 0, 1'b0, 8'h00);
      load_operands(2, 64'h123456789ABCDEF0, 64'h00000000FFFFFFFF);
      run_op(2, 3'd1, 0, 1'b0, 8'h00);
      load_operands(0, {48'd0, 16'($urandom)}, {48'd0, 16'($urandom)});
      run_op(0, 3'($urandom_range(0, 4)), 0, 1'b0, 8'h00);
      load_operands(2, {$urandom, $urandom}, {$urandom, $urandom});
      run_op(2, 3'($urandom_range(0, 4)), 0, 1'b0, 8'h00);

      // Reset mid-operation, then use the freshly loaded A.
      reset_mid_busy(1);
      run_op(1, 3'd2, 0, 1'b0, 8'h00);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/intercal_seq_alu.md
INTERCAL_SEQ_ALU -- requirements
Module: intercal_seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal values 16, 32, 64.
REQ-002 SHALL have parameter BYTES, default WIDTH/8, meaning number of byte lanes per operand; derived, not overridden.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ld_en  input  1  write ld_data into the operand byte chosen by ld_sel.
REQ-006 SHALL have port ld_sel  input  clog2(2*BYTES)  MSB 0 = operand A, 1 = B; low bits = byte index.
REQ-007 SHALL have port ld_data  input  8  operand byte.
REQ-008 SHALL have port op  input  3  0 MINGLE, 1 SELECT, 2 AND, 3 OR, 4 XOR, 5-7 illegal.
REQ-009 SHALL have port start  input  1  single-cycle request to begin the operation.
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port done  output  1  result valid; level.
REQ-012 SHALL have port err  output  1  last accepted op was illegal; level.
REQ-013 SHALL have port rd_sel  input  clog2(BYTES)  result byte index.
REQ-014 SHALL have port rd_data  output  8  combinational result byte.

Function
REQ-015 SHALL implement the FSM IDLE -> BUSY -> DONE; DONE -> BUSY on start; IDLE or DONE -> IDLE on ld_en without start.
REQ-016 SHALL accept start only in IDLE or DONE; in the accept cycle it latches op and copies A and B into working registers.
REQ-017 SHALL ignore start while BUSY, with no effect on state, operands or result.
REQ-018 SHALL drop ld_en writes while BUSY; in IDLE/DONE, a load in the accept cycle commits to A/B, but the op uses the pre-edge values.
REQ-019 SELECT SHALL scan bit i = 0..WIDTH-1, one bit per cycle: if B[i]=1, write A[i] to result[k] and increment k; result bits >= final k are 0.
REQ-020 SELECT SHALL hold busy for exactly WIDTH cycles after the accept edge; done rises on the next edge.
REQ-021 MINGLE SHALL produce result[2i+1]=A[i] and result[2i]=B[i] for i < WIDTH/2; the upper halves of A and B are ignored.
REQ-022 AND/OR/XOR SHALL produce A op rotr(A,1), where rotr(A,1) = {A[0], A[WIDTH-1:1]}.
REQ-023 MINGLE, AND, OR and XOR SHALL hold busy for exactly 1 cycle.
REQ-024 An illegal op SHALL hold busy for 1 cycle, then set result=0, err=1 and done=1.
REQ-025 err SHALL clear on the next accepted legal start.
REQ-026 done SHALL stay high until the next accepted start or ld_en; busy and done SHALL never be high together.
REQ-027 The result register SHALL update only on the BUSY->DONE edge; rd_data SHALL read the previous result throughout BUSY.
REQ-028 rd_data SHALL equal result[8*rd_sel+:8]; rd_sel >= BYTES SHALL return 0.

Reset
REQ-029 While rst=1: A, B, working registers, result, k and the bit counter SHALL be 0; state IDLE; busy=done=err=0.
REQ-030 rst asserted mid-BUSY SHALL abort the operation immediately with no partial result retained.
REQ-031 After rst deasserts, the first rising edge SHALL be able to accept ld_en or start.

Structure
REQ-032 Package intercal_pkg SHALL hold the op enum, the FSM state enum and the WIDTH legality check.
REQ-033 Sub-module intercal_select_serial SHALL contain the SELECT bit counter, the k pointer and the packing register, and report completion to the top FSM.

Verification
REQ-034 WIDTH=32, A=0x12345678, B=0x0000FFFF, SELECT -> busy exactly 32 cycles, then done=1, result 0x00005678.
REQ-035 WIDTH=32, A=0xFFFFFFFF, B=0x80000001, SELECT -> result 0x00000003; MINGLE with A=0x0000FFFF, B=0 -> 0xAAAAAAAA after 1 busy cycle.
REQ-036 WIDTH=32, A=0x00000003, AND -> 0x00000001; A=0x00000001, XOR -> 0x80000001; op=6 -> result 0, err=1.
REQ-037 During SELECT busy cycle 10: pulse start and ld_en (A byte0 = 0xEE) -> both ignored, result unchanged; rst pulse -> busy=done=0, result 0.
REQ-038 Same cycle, in DONE: start (SELECT) and ld_en (A byte0 = 0x00) -> op uses old A, new A is retained; WIDTH=16 and WIDTH=64 rerun REQ-034 scaled, busy = WIDTH cycles.
